data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
Shares the single-ported, clock-edge-registered data memory between two requesters: the processor load/store path (cpu_*) and a program/data loader or debug port (ld_*). Each cycle it grants at most one requester and drives the memory-side mem_read, mem_write and address/data buses. It returns read data tagged to the owner one cycle later and stalls the processor while it is not granted. Tie-breaking is round-robin, with a bounded loader lock for burst transfers.

Parameters:
ADDR_WIDTH, 32, width of address buses
DATA_WIDTH, 32, width of data buses
MAX_LOCK, 4, maximum consecutive loader grants under ld_lock while cpu_req is pending (1..15)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
cpu_req  input  1  processor memory access request (load or store)
cpu_we  input  2  store type: 00 read, 01 word store, 11 halfword store (low 16 bits, upper zeroed)
cpu_addr  input  ADDR_WIDTH  processor address
cpu_wdata  input  DATA_WIDTH  processor store data
cpu_stall  output  1  processor must hold PC and request this cycle
cpu_rdata  output  DATA_WIDTH  read data returned to processor
cpu_rvalid  output  1  cpu_rdata valid
ld_req  input  1  loader request
ld_lock  input  1  loader requests back-to-back ownership
ld_we  input  2  same encoding as cpu_we
ld_addr  input  ADDR_WIDTH  loader address
ld_wdata  input  DATA_WIDTH  loader store data
ld_gnt  output  1  loader access accepted this cycle
ld_rdata  output  DATA_WIDTH  read data returned to loader
ld_rvalid  output  1  ld_rdata valid
mem_read  output  1  to data memory read enable
mem_write  output  2  to data memory write type
mem_address  output  ADDR_WIDTH  to data memory address
mem_write_data  output  DATA_WIDTH  to data memory write data
mem_read_data  input  DATA_WIDTH  from data memory; valid after the edge a read is presented

Behaviour:
- Registered state: last_owner (CPU/LD), lock_cnt (4 bits), rd_owner (NONE/CPU/LD).
- Reset (reset_n=0 at posedge): last_owner=LD (so CPU wins the first tie), lock_cnt=0, rd_owner=NONE. cpu_rvalid=ld_rvalid=0 and rdata outputs 0 from the following cycle. Grant logic sees the reset state, so no grant is issued while reset_n=0: mem_read=0, mem_write=00, ld_gnt=0, cpu_stall=cpu_req.
- Grant (combinational from the registered state and current requests):
  - Only one requester active: that requester is granted.
  - Both active, ld_lock=1, last_owner=LD and lock_cnt<MAX_LOCK: LD is granted.
  - Both active otherwise: the requester other than last_owner is granted.
  - Neither active: no grant.
- Memory drive: the granted requester's addr/wdata/we are muxed out. mem_read=1 iff granted and we==00. mem_write=granted we, else 00. With no grant, all memory outputs are 0.
- cpu_stall = cpu_req & ~cpu_granted. ld_gnt = ld_req & ld_granted.
- On each posedge with a grant: last_owner updates to the granted requester. lock_cnt increments if LD is granted, ld_lock=1 and cpu_req=1 (saturating at MAX_LOCK); otherwise it clears to 0.
- Read return, latency exactly 1 cycle: rd_owner registers the grantee of a read. In the next cycle, the matching *_rvalid=1 and the matching *_rdata=mem_read_data. The non-owner's rdata holds its last value. Writes produce no rvalid.
- Grants in consecutive cycles pipeline: a read response and a new grant coexist.
- Unsupported we code 10 is treated as 00 (read).
- Reset mid-operation: a pending read response is dropped (rvalid=0 next cycle); lock and fairness state are reinitialised.

Test Plan:
- Reset then cpu_req=1, we=00, addr=5 with mem[5]=0x1234 -> same cycle mem_read=1, mem_address=5, cpu_stall=0; next cycle cpu_rvalid=1, cpu_rdata=0x1234, ld_rvalid=0.
- cpu_req=ld_req=1 (both reads) held 4 cycles after reset -> grants CPU, LD, CPU, LD; cpu_stall=0,1,0,1; rvalids alternate with 1-cycle lag.
- ld_lock=1, ld_req and cpu_req held 8 cycles, MAX_LOCK=4, last_owner=LD at start -> LD granted 4 cycles, then CPU for 1, then LD again.
- Loader halfword store addr=3, wdata=0xDEADBEEF, we=11 -> mem_write=11, mem_write_data=0xDEADBEEF passed through, ld_gnt=1, no ld_rvalid; following CPU read of addr 3 -> cpu_rdata=0x0000BEEF.
- CPU read granted, reset_n=0 on the next edge -> cpu_rvalid stays 0; after release, a tie grants CPU first.
- No requests -> mem_read=0, mem_write=00, mem_address=0, cpu_stall=0, ld_gnt=0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one single-ported, edge-registered data memory between the
//   processor load/store path (cpu_*) and a loader/debug port (ld_*).
//   At most one requester is granted per cycle. Ties are broken round-robin,
//   except that a locked loader may keep ownership for up to MAX_LOCK
//   consecutive grants while the processor waits. Read data comes back one
//   cycle after the grant and is steered to whoever issued the read.
//
// Ports
//   clk, reset_n         rising-edge clock, synchronous active-low reset
//   cpu_req/we/addr/wdata processor request (we: 00 rd, 01 word, 11 half)
//   cpu_stall            processor must hold its request this cycle
//   cpu_rdata/rvalid     read return to processor
//   ld_req/lock/we/addr/wdata  loader request, lock asks for back-to-back use
//   ld_gnt               loader access accepted this cycle
//   ld_rdata/rvalid      read return to loader
//   mem_read/write/address/write_data  memory-side request
//   mem_read_data        memory read data, valid the cycle after a read
module data_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic [1:0]            cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_stall,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic                  ld_req,
  input  logic                  ld_lock,
  input  logic [1:0]            ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_gnt,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  output logic                  ld_rvalid,
  output logic                  mem_read,
  output logic [1:0]            mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam logic [3:0] LOCK_LIMIT = 4'(MAX_LOCK);

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CPU  = 2'd1,
    RD_LD   = 2'd2
  } rd_owner_t;

  logic                  last_owner_ld_p1;
  logic [3:0]            lock_cnt_p1;
  rd_owner_t             rd_owner_p1;
  logic [DATA_WIDTH-1:0] cpu_rdata_hold_p1;
  logic [DATA_WIDTH-1:0] ld_rdata_hold_p1;

  logic                  cpu_granted;
  logic                  ld_granted;
  logic [1:0]            gnt_we;

  // Code 10 is not a store type; it behaves as a read.
  function automatic logic [1:0] norm_we(input logic [1:0] we);
    return (we == 2'b10) ? 2'b00 : we;
  endfunction

  function automatic logic [3:0] lock_next(input logic [3:0] cnt);
    return (cnt < LOCK_LIMIT) ? cnt + 4'd1 : LOCK_LIMIT;
  endfunction

  // ---- stage p0: grant decision from registered fairness state ----
  // Grants are suppressed while reset_n is low so the memory sees no
  // access during reset.
  always_comb begin
    cpu_granted = 1'b0;
    ld_granted  = 1'b0;
    if (reset_n) begin
      if (cpu_req && !ld_req) begin
        cpu_granted = 1'b1;
      end else if (ld_req && !cpu_req) begin
        ld_granted = 1'b1;
      end else if (cpu_req && ld_req) begin
        if (ld_lock && last_owner_ld_p1 && (lock_cnt_p1 < LOCK_LIMIT)) begin
          ld_granted = 1'b1;
        end else if (last_owner_ld_p1) begin
          cpu_granted = 1'b1;
        end else begin
          ld_granted = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_we         = 2'b00;
    mem_address    = '0;
    mem_write_data = '0;
    if (cpu_granted) begin
      gnt_we         = norm_we(cpu_we);
      mem_address    = cpu_addr;
      mem_write_data = cpu_wdata;
    end else if (ld_granted) begin
      gnt_we         = norm_we(ld_we);
      mem_address    = ld_addr;
      mem_write_data = ld_wdata;
    end
    mem_read  = (cpu_granted || ld_granted) && (gnt_we == 2'b00);
    mem_write = gnt_we;
  end

  assign cpu_stall = cpu_req & ~cpu_granted;
  assign ld_gnt    = ld_req & ld_granted;

  // ---- stage p1: fairness state and read-return ownership ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_owner_ld_p1  <= 1'b1;
      lock_cnt_p1       <= 4'd0;
      rd_owner_p1       <= RD_NONE;
      cpu_rdata_hold_p1 <= '0;
      ld_rdata_hold_p1  <= '0;
    end else begin
      // Capture the returning word so each side keeps its last read value.
      if (rd_owner_p1 == RD_CPU) cpu_rdata_hold_p1 <= mem_read_data;
      if (rd_owner_p1 == RD_LD)  ld_rdata_hold_p1  <= mem_read_data;

      if (cpu_granted || ld_granted) begin
        last_owner_ld_p1 <= ld_granted;
        // The lock counter only runs while the loader is actually
        // holding off a waiting processor.
        if (ld_granted && ld_lock && cpu_req) begin
          lock_cnt_p1 <= lock_next(lock_cnt_p1);
        end else begin
          lock_cnt_p1 <= 4'd0;
        end
      end

      if (mem_read) begin
        rd_owner_p1 <= cpu_granted ? RD_CPU : RD_LD;
      end else begin
        rd_owner_p1 <= RD_NONE;
      end
    end
  end

  // Memory data arrives in the cycle after the read edge; pass it straight
  // through to the owner, otherwise present the held value.
  assign cpu_rvalid = (rd_owner_p1 == RD_CPU);
  assign ld_rvalid  = (rd_owner_p1 == RD_LD);
  assign cpu_rdata  = cpu_rvalid ? mem_read_data : cpu_rdata_hold_p1;
  assign ld_rdata   = ld_rvalid  ? mem_read_data : ld_rdata_hold_p1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int ML = 4;
  localparam logic [31:0] CW = 32'h1111_1111;
  localparam logic [31:0] LW = 32'h2222_2222;
  localparam logic [31:0] A1 = 32'hA000_0001;
  localparam logic [31:0] A2 = 32'hA000_0002;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          cpu_req;
  logic [1:0]    cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          ld_req;
  logic          ld_lock;
  logic [1:0]    ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic [DW-1:0] ld_rdata;
  logic          ld_rvalid;
  logic          mem_read;
  logic [1:0]    mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;

  data_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ld_req(ld_req), .ld_lock(ld_lock), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 5) ? 32'h0000_1234 : (32'hA000_0000 | 32'(i));
  endfunction

  // Edge-registered data memory attached to the DUT.
  logic [DW-1:0] mem_arr [0:63];
  logic mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else begin
      if (mem_write == 2'b01) mem_arr[mem_address[5:0]] <= mem_write_data;
      else if (mem_write == 2'b11) mem_arr[mem_address[5:0]] <= mem_write_data & 32'h0000_FFFF;
      if (mem_read) mem_read_data <= mem_arr[mem_address[5:0]];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner codes: 0 none, 1 processor, 2 loader.
  bit          m_last_ld;
  int          m_streak;
  int          m_pend;
  logic [31:0] m_pend_data;
  logic [31:0] m_cpu_hold;
  logic [31:0] m_ld_hold;
  logic [31:0] ref_mem [0:63];

  function automatic int model_grant();
    if (!reset_n) return 0;
    if (cpu_req && ld_req) begin
      if (ld_lock && m_last_ld && m_streak < ML) return 2;
      return m_last_ld ? 1 : 2;
    end
    if (cpu_req) return 1;
    if (ld_req) return 2;
    return 0;
  endfunction

  function automatic logic [1:0] model_we(input int g);
    logic [1:0] w;
    w = (g == 1) ? cpu_we : (g == 2) ? ld_we : 2'b00;
    if (w == 2'b10) w = 2'b00;
    return w;
  endfunction

  task automatic model_update();
    int g;
    logic [1:0] w;
    logic [31:0] a;
    logic [31:0] d;
    g = model_grant();
    if (!reset_n) begin
      m_last_ld = 1'b1; m_streak = 0; m_pend = 0; m_cpu_hold = '0; m_ld_hold = '0;
    end else begin
      if (m_pend == 1) m_cpu_hold = m_pend_data;
      if (m_pend == 2) m_ld_hold = m_pend_data;
      m_pend = 0;
      if (g != 0) begin
        w = model_we(g);
        a = (g == 1) ? cpu_addr : ld_addr;
        d = (g == 1) ? cpu_wdata : ld_wdata;
        m_last_ld = (g == 2);
        if (g == 2 && ld_lock && cpu_req) m_streak = (m_streak + 1 > ML) ? ML : m_streak + 1;
        else m_streak = 0;
        if (w == 2'b00) begin
          m_pend = g;
          m_pend_data = ref_mem[a[5:0]];
        end else if (w == 2'b01) begin
          ref_mem[a[5:0]] = d;
        end else begin
          ref_mem[a[5:0]] = {16'h0000, d[15:0]};
        end
      end
    end
  endtask

  task automatic check_model(input int cyc);
    int g;
    logic [1:0] w;
    string p;
    g = model_grant();
    w = model_we(g);
    p = $sformatf("rnd%0d", cyc);
    chk({p, ".cpu_stall"}, 64'(cpu_stall), 64'(cpu_req && g != 1));
    chk({p, ".ld_gnt"}, 64'(ld_gnt), 64'(g == 2));
    chk({p, ".mem_read"}, 64'(mem_read), 64'(g != 0 && w == 2'b00));
    chk({p, ".mem_write"}, 64'(mem_write), 64'(w));
    chk({p, ".mem_address"}, 64'(mem_address), (g == 1) ? 64'(cpu_addr) : (g == 2) ? 64'(ld_addr) : 64'd0);
    chk({p, ".mem_write_data"}, 64'(mem_write_data), (g == 1) ? 64'(cpu_wdata) : (g == 2) ? 64'(ld_wdata) : 64'd0);
    chk({p, ".cpu_rvalid"}, 64'(cpu_rvalid), 64'(m_pend == 1));
    chk({p, ".ld_rvalid"}, 64'(ld_rvalid), 64'(m_pend == 2));
    chk({p, ".cpu_rdata"}, 64'(cpu_rdata), 64'((m_pend == 1) ? m_pend_data : m_cpu_hold));
    chk({p, ".ld_rdata"}, 64'(ld_rdata), 64'((m_pend == 2) ? m_pend_data : m_ld_hold));
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rst;
    logic        cr;
    logic [1:0]  cw;
    logic [31:0] ca;
    logic        lr;
    logic        ll;
    logic [1:0]  lw;
    logic [31:0] la;
    logic [31:0] lwd;
    logic        e_stall;
    logic        e_gnt;
    logic        e_mrd;
    logic [1:0]  e_mwr;
    logic [31:0] e_maddr;
    logic [31:0] e_mwd;
    logic        e_crv;
    logic        e_lrv;
    logic [31:0] e_crd;
    logic [31:0] e_lrd;
    logic        ck_rd;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic cr, input logic [1:0] cw, input logic [31:0] ca,
    input logic lr, input logic ll, input logic [1:0] lw, input logic [31:0] la, input logic [31:0] lwd,
    input logic es, input logic eg, input logic em, input logic [1:0] ew, input logic [31:0] ea,
    input logic [31:0] ewd, input logic crv, input logic lrv, input logic [31:0] crd,
    input logic [31:0] lrd, input logic ck);
    vec_t v;
    v.rst = rst; v.cr = cr; v.cw = cw; v.ca = ca; v.lr = lr; v.ll = ll; v.lw = lw; v.la = la; v.lwd = lwd;
    v.e_stall = es; v.e_gnt = eg; v.e_mrd = em; v.e_mwr = ew; v.e_maddr = ea; v.e_mwd = ewd;
    v.e_crv = crv; v.e_lrv = lrv; v.e_crd = crd; v.e_lrd = lrd; v.ck_rd = ck;
    return v;
  endfunction

  vec_t vecs [$];

  task automatic drive_idle();
    reset_n = 1'b1; cpu_req = 1'b0; cpu_we = 2'b00; cpu_addr = '0; cpu_wdata = CW;
    ld_req = 1'b0; ld_lock = 1'b0; ld_we = 2'b00; ld_addr = '0; ld_wdata = LW;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    m_last_ld = 1'b1; m_streak = 0; m_pend = 0;
    m_pend_data = '0; m_cpu_hold = '0; m_ld_hold = '0;
    drive_idle();
    reset_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      model_update();
    end

    // rst cr cw ca   lr ll lw la lwd | stall gnt mrd mwr maddr mwd | crv lrv crd lrd ck
    vecs.push_back(mk(0,1,0,5, 0,0,0,0,LW,           1,0,0,0,0,0,            0,0,0,0,1));   // reset holds off
    vecs.push_back(mk(1,1,0,5, 0,0,0,0,LW,           0,0,1,0,5,CW,           0,0,0,0,1));   // cpu read addr 5
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,LW,           0,0,0,0,0,0,            1,0,32'h1234,0,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0,LW,           0,0,0,0,0,0,            0,0,32'h1234,0,1));
    vecs.push_back(mk(1,1,0,1, 1,0,0,2,LW,           0,0,1,0,1,CW,           0,0,0,0,1));   // tie: cpu first
    vecs.push_back(mk(1,1,0,1, 1,0,0,2,LW,           1,1,1,0,2,LW,           1,0,A1,0,1));
    vecs.push_back(mk(1,1,0,1, 1,0,0,2,LW,           0,0,1,0,1,CW,           0,1,A1,A2,1));
    vecs.push_back(mk(1,1,0,1, 1,0,0,2,LW,           1,1,1,0,2,LW,           1,0,A1,A2,1));
    for (int k = 0; k < 4; k++)                                                           // locked burst
      vecs.push_back(mk(1,1,0,1, 1,1,0,2,LW,         1,1,1,0,2,LW,           0,1,A1,A2,1));
    vecs.push_back(mk(1,1,0,1, 1,1,0,2,LW,           0,0,1,0,1,CW,           0,1,A1,A2,1)); // lock expired
    vecs.push_back(mk(1,1,0,1, 1,1,0,2,LW,           1,1,1,0,2,LW,           1,0,A1,A2,1));
    vecs.push_back(mk(1,1,0,1, 1,1,0,2,LW,           1,1,1,0,2,LW,           0,1,A1,A2,1));
    vecs.push_back(mk(1,1,0,1, 1,1,0,2,LW,           1,1,1,0,2,LW,           0,1,A1,A2,1));
    vecs.push_back(mk(1,0,0,0, 1,0,3,3,32'hDEADBEEF, 0,1,0,3,3,32'hDEADBEEF, 0,1,A1,A2,1)); // halfword store
    vecs.push_back(mk(1,1,0,3, 0,0,0,0,LW,           0,0,1,0,3,CW,           0,0,A1,A2,1));
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,LW,           0,0,0,0,0,0,            1,0,32'hBEEF,A2,1));
    vecs.push_back(mk(1,1,2,3, 0,0,0,0,LW,           0,0,1,0,3,CW,           0,0,32'hBEEF,A2,1)); // we=10 reads
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,LW,           0,0,0,0,0,0,            1,0,32'hBEEF,A2,1));
    vecs.push_back(mk(1,1,0,5, 0,0,0,0,LW,           0,0,1,0,5,CW,           0,0,32'hBEEF,A2,1));
    vecs.push_back(mk(0,1,0,5, 1,0,0,2,LW,           1,0,0,0,0,0,            0,0,0,0,0));   // reset mid-read
    vecs.push_back(mk(1,1,0,5, 1,0,0,2,LW,           0,0,1,0,5,CW,           0,0,0,0,1));   // response dropped, cpu wins tie
    vecs.push_back(mk(1,1,0,5, 1,0,0,2,LW,           1,1,1,0,2,LW,           1,0,32'h1234,0,1));
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,LW,           0,0,0,0,0,0,            0,1,32'h1234,A2,1)); // idle

    foreach (vecs[i]) begin
      string p;
      p = $sformatf("vec%0d", i);
      @(negedge clk);
      reset_n = vecs[i].rst; cpu_req = vecs[i].cr; cpu_we = vecs[i].cw; cpu_addr = vecs[i].ca;
      cpu_wdata = CW; ld_req = vecs[i].lr; ld_lock = vecs[i].ll; ld_we = vecs[i].lw;
      ld_addr = vecs[i].la; ld_wdata = vecs[i].lwd;
      #2;
      chk({p, ".cpu_stall"}, 64'(cpu_stall), 64'(vecs[i].e_stall));
      chk({p, ".ld_gnt"}, 64'(ld_gnt), 64'(vecs[i].e_gnt));
      chk({p, ".mem_read"}, 64'(mem_read), 64'(vecs[i].e_mrd));
      chk({p, ".mem_write"}, 64'(mem_write), 64'(vecs[i].e_mwr));
      chk({p, ".mem_address"}, 64'(mem_address), 64'(vecs[i].e_maddr));
      chk({p, ".mem_write_data"}, 64'(mem_write_data), 64'(vecs[i].e_mwd));
      if (vecs[i].ck_rd) begin
        chk({p, ".cpu_rvalid"}, 64'(cpu_rvalid), 64'(vecs[i].e_crv));
        chk({p, ".ld_rvalid"}, 64'(ld_rvalid), 64'(vecs[i].e_lrv));
        chk({p, ".cpu_rdata"}, 64'(cpu_rdata), 64'(vecs[i].e_crd));
        chk({p, ".ld_rdata"}, 64'(ld_rdata), 64'(vecs[i].e_lrd));
      end
      @(posedge clk);
      model_update();
    end

    // Randomized traffic against the model, including occasional resets.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      reset_n   = ($urandom_range(0, 39) != 0);
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_we    = 2'($urandom_range(0, 3));
      cpu_addr  = 32'($urandom_range(0, 7));
      cpu_wdata = $urandom;
      ld_req    = ($urandom_range(0, 3) != 0);
      ld_lock   = ($urandom_range(0, 2) != 0);
      ld_we     = 2'($urandom_range(0, 3));
      ld_addr   = 32'($urandom_range(0, 7));
      ld_wdata  = $urandom;
      #2;
      check_model(c);
      @(posedge clk);
      model_update();
    end

    @(negedge clk);
    drive_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
